sort_stream_controller: RTL and testbench
=========================================

SORT_STREAM_CONTROLLER -- requirements
Module: sort_stream_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the element width in bits, matching the downstream sorter.
REQ-002 SHALL have parameter SIZE, default 3, meaning the sorter capacity in elements, with SIZE >= 2.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock and all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream element valid.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  upstream element.
REQ-007 SHALL have port in_last  input  1  marks the final element of the frame.
REQ-008 SHALL have port in_ready  output  1  block accepts an element this cycle.
REQ-009 SHALL have port out_valid  output  1  sorted element valid.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  sorted element, in ascending order.
REQ-011 SHALL have port out_last  output  1  marks the final sorted element of the frame.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the sorted element.
REQ-013 SHALL have port sorter_clear  output  1  reset for the sorter.
REQ-014 SHALL have port sorter_enable  output  1  enable for the sorter.
REQ-015 SHALL have port sorter_write  output  1  sorter mode: 1 = insert, 0 = shift out.
REQ-016 SHALL have port sorter_unsorted_data  output  DATA_WIDTH  element sent to the sorter.
REQ-017 SHALL have port sorter_sorted_data  input  DATA_WIDTH  head (minimum) cell of the sorter.
REQ-018 SHALL have port truncated  output  1  one-cycle pulse when a frame is closed at SIZE elements without in_last.

Function
REQ-019 SHALL implement a state machine with three states: CLEAR, LOAD and DRAIN.
REQ-020 SHALL stay in CLEAR for exactly one cycle and then move to LOAD.
REQ-021 SHALL drive sorter_clear = (state == CLEAR).
REQ-022 SHALL drive in_ready = (state == LOAD).
REQ-023 SHALL treat an element as accepted when in_valid && in_ready.
REQ-024 SHALL drive sorter_enable = (accept in LOAD) || (out_valid && out_ready in DRAIN); sorter_enable is combinational and has zero latency.
REQ-025 SHALL drive sorter_write = (state == LOAD) and sorter_unsorted_data = in_data.
REQ-026 SHALL keep a load counter of width $clog2(SIZE+1); the counter clears in CLEAR and increments on each accept.
REQ-027 SHALL leave LOAD for DRAIN on the edge of an accept that has in_last = 1 or that makes the counter equal SIZE.
REQ-028 SHALL, when the SIZE-th accept has in_last = 0, pulse truncated for that accept cycle only.
REQ-029 SHALL treat elements following a truncation as the next frame.
REQ-030 SHALL, on entering DRAIN, copy the load count into a drain counter.
REQ-031 SHALL assert out_valid in DRAIN while the drain counter > 0.
REQ-032 SHALL drive out_data = sorter_sorted_data combinationally.
REQ-033 SHALL assert out_last when out_valid is high and the drain counter == 1.
REQ-034 SHALL decrement the drain counter on each out_valid && out_ready.
REQ-035 SHALL, on the handshake with out_last, move from DRAIN to CLEAR.
REQ-036 SHALL, while out_ready = 0, hold out_valid and out_data stable and keep sorter_enable low.
REQ-037 SHALL give a first out_valid 1 cycle after the final accept, and then 1 element per cycle when out_ready stays high.
REQ-038 SHALL require the sorter to update its cells on the edge where sorter_enable is sampled high.
REQ-039 SHALL NOT allow an empty frame; in_last always travels with an element.
REQ-040 SHALL ignore in_last and in_valid outside LOAD.

Reset
REQ-041 SHALL, while reset is high and independent of clk, put the state in CLEAR and both counters at 0.
REQ-042 SHALL, while reset is high, drive in_ready=0, out_valid=0, out_last=0, sorter_enable=0, sorter_write=0, truncated=0 and sorter_clear=1.
REQ-043 SHALL, on release of reset, spend one CLEAR cycle before in_ready rises.
REQ-044 SHALL, on reset during LOAD or DRAIN, discard the frame in progress without emitting any further output.

Verification
REQ-045 SHALL cover (SIZE=3): frame 5,1,3 with last on 3 -> out 1,3,5, out_last only with 5, then one sorter_clear cycle.
REQ-046 SHALL cover: frame 9,2 with last on 2 -> out 2,9, out_last with 9, truncated stays 0.
REQ-047 SHALL cover: stream 4,8,6,1 with no in_last -> truncated pulses at accept of 6 and out is 4,6,8; element 1 then opens the next frame.
REQ-048 SHALL cover: frame 7,7,0 with out_ready held low for 3 cycles -> out_data held at 0, sorter_enable held at 0, then out 0,7,7.
REQ-049 SHALL cover: reset asserted mid-DRAIN -> out_valid drops to 0 immediately and sorter_clear goes to 1; after release, exactly one CLEAR cycle, then in_ready=1.
REQ-050 SHALL cover: back-to-back frames with in_valid held high -> in_ready low during DRAIN and CLEAR, and no element lost or duplicated.

Source files
------------

// File: rtl/sort_stream_controller.sv
// Stream front end for an insertion sorter: loads one frame into the sorter,
// then drains it in ascending order with valid/ready handshakes on both sides.
module sort_stream_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int SIZE       = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  sorter_clear,
   output logic                  sorter_enable,
   output logic                  sorter_write,
   output logic [DATA_WIDTH-1:0] sorter_unsorted_data,
   input  logic [DATA_WIDTH-1:0] sorter_sorted_data,
   output logic                  truncated
);

   localparam int CW = $clog2(SIZE + 1);
   localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_DRAIN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] load_cnt, load_nxt;
   logic [CW-1:0] drain_cnt, drain_nxt;
   logic          accept, pop, full_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_CLEAR;
         load_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         load_cnt  <= load_nxt;
         drain_cnt <= drain_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_nxt  = load_cnt;
      drain_nxt = drain_cnt;
      in_ready  = (state == S_LOAD);
      accept    = in_valid && in_ready;
      out_valid = (state == S_DRAIN) && (drain_cnt != '0);
      pop       = out_valid && out_ready;
      out_last  = out_valid && (drain_cnt == ONE_C);
      // this accept fills the sorter to capacity
      full_next = (load_cnt + ONE_C) == SIZE_C;
      truncated = accept && full_next && !in_last;
      unique case (state)
         S_CLEAR: begin
            load_nxt  = '0;
            drain_nxt = '0;
            state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (accept) begin
               load_nxt = load_cnt + ONE_C;
               if (in_last || full_next) begin
                  drain_nxt = load_cnt + ONE_C;
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop) begin
               drain_nxt = drain_cnt - ONE_C;
               if (drain_cnt == ONE_C) state_nxt = S_CLEAR;
            end else if (drain_cnt == '0) begin
               // unreachable with legal frames; recovers instead of hanging
               state_nxt = S_CLEAR;
            end
         end
         default: state_nxt = S_CLEAR;
      endcase
   end

   assign sorter_clear         = (state == S_CLEAR);
   assign sorter_write         = (state == S_LOAD);
   assign sorter_unsorted_data = in_data;
   assign sorter_enable        = accept || pop;
   assign out_data             = sorter_sorted_data;

endmodule

// File: tb/tb_sort_stream_controller.sv
// Randomized and directed bench for sort_stream_controller with a behavioural
// sorter stub and a frame-level reference model (split, sort, concatenate).
module tb_sort_stream_controller;
   localparam int DW   = 8;
   localparam int SIZE = 3;

   logic          clk = 1'b0;
   logic          reset, in_valid, in_last, out_ready;
   logic [DW-1:0] in_data;
   logic          in_ready, out_valid, out_last, truncated;
   logic [DW-1:0] out_data, sorter_unsorted_data, sorter_sorted_data;
   logic          sorter_clear, sorter_enable, sorter_write;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sort_stream_controller #(.DATA_WIDTH(DW), .SIZE(SIZE)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .sorter_clear(sorter_clear), .sorter_enable(sorter_enable), .sorter_write(sorter_write),
      .sorter_unsorted_data(sorter_unsorted_data), .sorter_sorted_data(sorter_sorted_data),
      .truncated(truncated)
   );

   // Sorter stub: controls are captured mid-cycle, cells update on the rising edge.
   logic [DW-1:0] srt_q[$];
   logic          m_clr = 1'b1, m_en = 1'b0, m_wr = 1'b0;
   logic [DW-1:0] m_din = '0;
   logic [DW-1:0] head = '0;
   assign sorter_sorted_data = head;

   initial forever begin
      @(negedge clk);
      m_clr = sorter_clear; m_en = sorter_enable; m_wr = sorter_write; m_din = sorter_unsorted_data;
   end

   initial forever begin
      @(posedge clk);
      if (m_clr) srt_q.delete();
      else if (m_en) begin
         if (m_wr) begin srt_q.push_back(m_din); srt_q.sort(); end
         else if (srt_q.size() > 0) void'(srt_q.pop_front());
      end
      head = (srt_q.size() > 0) ? srt_q[0] : '0;
   end

   // Stimulus, observations and reference expectations
   logic [DW-1:0] st_data[$];  bit st_last[$];
   logic [DW-1:0] ob_data[$];  bit ob_last[$];  bit ob_trunc[$];
   logic [DW-1:0] exp_data[$]; bit exp_last[$]; bit exp_trunc[$];
   int exp_frames, clr_cycles, proto_err, lat_bad, stall_bad, hold_cycles;
   bit timed_out;

   // Cut the stream at in_last or at SIZE elements, sort each piece.
   function automatic void ref_model();
      logic [DW-1:0] fb[$];
      exp_data.delete(); exp_last.delete(); exp_trunc.delete(); exp_frames = 0;
      foreach (st_data[i]) begin
         fb.push_back(st_data[i]);
         if (st_last[i] || fb.size() == SIZE) begin
            exp_trunc.push_back(!st_last[i]);
            fb.sort();
            foreach (fb[j]) begin exp_data.push_back(fb[j]); exp_last.push_back(j == fb.size() - 1); end
            exp_frames++;
            fb.delete();
         end else exp_trunc.push_back(1'b0);
      end
   endfunction

   // Drives st_* and records what the DUT does; comparisons live in the tests.
   task automatic run_stream(input int gap_pct, input int stall_pct);
      int idx = 0, fill = 0, cyc = 0, tail = 0;
      bit expect_ov = 0, stalled = 0;
      logic [DW-1:0] held = '0;
      ob_data.delete(); ob_last.delete(); ob_trunc.delete();
      clr_cycles = 0; proto_err = 0; lat_bad = 0; stall_bad = 0; timed_out = 0;
      ref_model();
      while (tail < 2 && !timed_out) begin
         @(posedge clk); #1;
         in_valid = (idx < st_data.size()) && ($urandom_range(99) >= gap_pct);
         in_data  = in_valid ? st_data[idx] : DW'($urandom);
         in_last  = in_valid ? st_last[idx] : 1'($urandom_range(1));
         if (out_valid && hold_cycles > 0) begin out_ready = 0; hold_cycles--; end
         else out_ready = ($urandom_range(99) >= stall_pct);
         @(negedge clk);
         if (expect_ov && !out_valid) lat_bad++;
         if (stalled && (!out_valid || out_data !== held)) stall_bad++;
         if (out_valid && !out_ready && sorter_enable) stall_bad++;
         if (sorter_enable !== ((in_valid && in_ready) || (out_valid && out_ready))) proto_err++;
         if (sorter_write !== in_ready || (in_ready && (out_valid || sorter_clear))) proto_err++;
         if (sorter_unsorted_data !== in_data || (out_last && !out_valid)) proto_err++;
         if (sorter_clear) clr_cycles++;
         expect_ov = 0;
         if (in_valid && in_ready) begin
            ob_trunc.push_back(truncated);
            idx++; fill++;
            if (in_last || fill == SIZE) begin expect_ov = 1; fill = 0; end
         end else if (truncated) proto_err++;
         if (out_valid && out_ready) begin ob_data.push_back(out_data); ob_last.push_back(out_last); end
         stalled = out_valid && !out_ready;
         held = out_data;
         if (idx == st_data.size() && ob_data.size() >= exp_data.size()) tail++;
         if (++cyc > 4000) timed_out = 1;
      end
      in_valid = 0;
      out_ready = 1;
   endtask

   task automatic test_reset();
      reset = 1; in_valid = 1; in_data = 8'h55; in_last = 1; out_ready = 1;
      #1;
      checks++;
      if ({in_ready, out_valid, out_last, sorter_enable, sorter_write, truncated, sorter_clear} !== 7'b0000001) begin
         failures++;
         $display("FAIL reset_outputs: got %b want 0000001",
                  {in_ready, out_valid, out_last, sorter_enable, sorter_write, truncated, sorter_clear});
      end
      repeat (3) @(posedge clk);
      #1; reset = 0; in_valid = 0;
      @(negedge clk);
      checks++;
      if ({sorter_clear, in_ready} !== 2'b10) begin
         failures++; $display("FAIL reset_clear_cycle: clear/ready got %b want 10", {sorter_clear, in_ready});
      end
      @(negedge clk);
      checks++;
      if ({sorter_clear, in_ready} !== 2'b01) begin
         failures++; $display("FAIL reset_load_entry: clear/ready got %b want 01", {sorter_clear, in_ready});
      end
   endtask

   task automatic test_stream_scenarios();
      string name;
      int gap, stall, n;
      for (int s = 0; s < 9; s++) begin
         gap = 0; stall = 0; hold_cycles = 0;
         case (s)
            0: begin name = "basic";      st_data = {8'd5, 8'd1, 8'd3}; st_last = {1'b0, 1'b0, 1'b1}; end
            1: begin name = "short";      st_data = {8'd9, 8'd2};       st_last = {1'b0, 1'b1}; end
            2: begin name = "truncate";   st_data = {8'd4, 8'd8, 8'd6, 8'd1, 8'd5};
                                          st_last = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; end
            3: begin name = "backpress";  st_data = {8'd7, 8'd7, 8'd0}; st_last = {1'b0, 1'b0, 1'b1};
                                          hold_cycles = 3; end
            4: begin name = "back2back";  st_data = {8'd3, 8'd1, 8'd2, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd0};
                                          st_last = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; end
            default: begin
               name = "random"; gap = 20; stall = 30;
               st_data.delete(); st_last.delete();
               n = $urandom_range(20, 6);
               for (int i = 0; i < n; i++) begin
                  st_data.push_back((s % 2) ? DW'($urandom_range(15)) : DW'($urandom));
                  st_last.push_back((i == n - 1) || ($urandom_range(99) < 30));
               end
            end
         endcase
         run_stream(gap, stall);
         checks++;
         if (timed_out || ob_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d outputs (timeout=%0b) want %0d", name, ob_data.size(), timed_out, exp_data.size());
         end
         foreach (exp_data[i]) begin
            checks++;
            if (i >= ob_data.size() || ob_data[i] !== exp_data[i] || ob_last[i] !== exp_last[i]) begin
               failures++;
               $display("FAIL %s_out[%0d]: got %0d/last=%0b want %0d/last=%0b", name, i,
                        (i < ob_data.size()) ? ob_data[i] : 'x, (i < ob_last.size()) ? ob_last[i] : 1'b0,
                        exp_data[i], exp_last[i]);
            end
         end
         foreach (exp_trunc[i]) begin
            checks++;
            if (i >= ob_trunc.size() || ob_trunc[i] !== exp_trunc[i]) begin
               failures++;
               $display("FAIL %s_trunc[%0d]: got %0b want %0b", name, i,
                        (i < ob_trunc.size()) ? ob_trunc[i] : 1'b0, exp_trunc[i]);
            end
         end
         checks++;
         if (proto_err != 0 || lat_bad != 0 || stall_bad != 0) begin
            failures++;
            $display("FAIL %s_protocol: proto=%0d latency=%0d stall=%0d want all 0", name, proto_err, lat_bad, stall_bad);
         end
         checks++;
         if (clr_cycles != exp_frames) begin
            failures++; $display("FAIL %s_clear_cycles: got %0d want %0d", name, clr_cycles, exp_frames);
         end
         if (s == 0) begin
            checks++;
            if (ob_data.size() != 3 || {ob_data[0], ob_data[1], ob_data[2]} !== {8'd1, 8'd3, 8'd5}) begin
               failures++; $display("FAIL basic_const: got %p want 1,3,5", ob_data);
            end
         end
         if (s == 3) begin
            checks++;
            if (ob_data.size() != 3 || {ob_data[0], ob_data[1], ob_data[2]} !== {8'd0, 8'd7, 8'd7}) begin
               failures++; $display("FAIL backpress_const: got %p want 0,7,7", ob_data);
            end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      logic [DW-1:0] vals[3] = '{8'd30, 8'd10, 8'd20};
      int guard = 0;
      out_ready = 0;
      for (int i = 0; i < 3 && guard < 50; guard++) begin
         @(posedge clk); #1;
         in_valid = 1; in_data = vals[i]; in_last = (i == 2);
         @(negedge clk);
         if (in_ready) i++;
      end
      @(posedge clk); #1;
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd10) begin
         failures++; $display("FAIL middrain_setup: valid/data got %b/%0d want 1/10", out_valid, out_data);
      end
      reset = 1; out_ready = 1;
      #1;
      checks++;
      if ({out_valid, out_last, sorter_enable, sorter_clear, in_ready} !== 5'b00010) begin
         failures++;
         $display("FAIL middrain_reset: valid/last/en/clear/ready got %b want 00010",
                  {out_valid, out_last, sorter_enable, sorter_clear, in_ready});
      end
      repeat (2) @(posedge clk);
      #1; reset = 0;
      @(negedge clk);
      checks++;
      if ({sorter_clear, in_ready, out_valid} !== 3'b100) begin
         failures++; $display("FAIL middrain_clear_cycle: clear/ready/valid got %b want 100", {sorter_clear, in_ready, out_valid});
      end
      @(negedge clk);
      checks++;
      if ({sorter_clear, in_ready, out_valid} !== 3'b010) begin
         failures++; $display("FAIL middrain_load_entry: clear/ready/valid got %b want 010", {sorter_clear, in_ready, out_valid});
      end
      st_data = {8'd200, 8'd100}; st_last = {1'b0, 1'b1}; hold_cycles = 0;
      run_stream(0, 0);
      checks++;
      if (timed_out || ob_data.size() != 2 || {ob_data[0], ob_data[1]} !== {8'd100, 8'd200} || ob_last[1] !== 1'b1) begin
         failures++; $display("FAIL middrain_next_frame: got %p want 100,200 (stale frame must be gone)", ob_data);
      end
   endtask

   initial begin
      in_valid = 0; in_data = '0; in_last = 0; out_ready = 1; reset = 1;
      test_reset();
      test_stream_scenarios();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
